// File: rtl/data_bus_seq_if.sv
// data_bus_seq_if
//   Bundles the request side and the external pin side of the data-bus
//   cycle sequencer.
//   master : requester / bench side (drives requests, nwait and pin inputs)
//   slave  : sequencer side (drives strobes, pin outputs, capture and status)
//   Signals:
//     rd_req, wr_req  single-cycle read / write request pulses
//     wr_data         write byte, taken when wr_req is accepted
//     nwait           external wait, active low
//     pin_d_in        data pins, input side
//     pin_d_out       data pins, output side
//     pin_d_oe        pin output enable
//     nmreq/nrd/nwr   active-low bus strobes
//     rd_data         captured read byte
//     latch_we        one-cycle load strobe for the downstream latch
//     busy/done/err   status: cycle in progress, completion pulse, timeout pulse
interface data_bus_seq_if #(
  parameter int DW = 8
);
  logic          rd_req;
  logic          wr_req;
  logic [DW-1:0] wr_data;
  logic          nwait;
  logic [DW-1:0] pin_d_in;
  logic [DW-1:0] pin_d_out;
  logic          pin_d_oe;
  logic          nmreq;
  logic          nrd;
  logic          nwr;
  logic [DW-1:0] rd_data;
  logic          latch_we;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output rd_req, wr_req, wr_data, nwait, pin_d_in,
    input  pin_d_out, pin_d_oe, nmreq, nrd, nwr, rd_data, latch_we, busy, done, err
  );

  modport slave (
    input  rd_req, wr_req, wr_data, nwait, pin_d_in,
    output pin_d_out, pin_d_oe, nmreq, nrd, nwr, rd_data, latch_we, busy, done, err
  );
endinterface

// File: rtl/data_bus_seq.sv
// data_bus_seq
//   Z80-style external memory bus cycle sequencer sitting in front of the
//   8-bit data-bus latch. Runs read and write cycles through T1, T2, optional
//   wait states (TW) and T3, drives the control strobes and data pins, and on
//   reads captures the pin byte and pulses latch_we so the latch loads it.
//   Every output is a flop; strobes are decoded from the next state so they
//   line up exactly with the registered state.
//   Parameters:
//     DW           data width of pins and internal bus
//     WAIT_TIMEOUT max consecutive TW cycles before forced completion (0 = off)
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous, active-high
//     bus    data_bus_seq_if slave modport (requests, pins, strobes, status)
module data_bus_seq #(
  parameter int DW           = 8,
  parameter int WAIT_TIMEOUT = 0
) (
  input  logic           clk,
  input  logic           reset,
  data_bus_seq_if.slave  bus
);

  localparam int CNT_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_TW   = 3'd3,
    S_T3   = 3'd4
  } state_t;

  state_t             state_p0, state_nxt;
  logic               is_rd_p0, is_rd_nxt;
  logic [CNT_W-1:0]   wait_cnt_p0, wait_cnt_nxt;
  logic               timeout_p0, timeout_nxt;
  logic               timeout_hit;
  logic               req;
  logic               accept;
  logic               wr_cap;
  logic               rd_cap;
  logic               finish;

  logic               nmreq_nxt;
  logic               nrd_nxt;
  logic               nwr_nxt;
  logic               oe_nxt;
  logic               busy_nxt;
  logic               done_nxt;
  logic               err_nxt;
  logic               lwe_nxt;

  // The current TW cycle is the WAIT_TIMEOUT-th one when the count of
  // completed TW cycles plus this one reaches the limit.
  assign timeout_hit = (WAIT_TIMEOUT > 0) &&
                       ((int'(wait_cnt_p0) + 1) == WAIT_TIMEOUT);

  assign req    = bus.rd_req | bus.wr_req;
  assign finish = (state_p0 == S_T3);

  // Next-state, request acceptance and output decode
  always_comb begin
    state_nxt    = state_p0;
    is_rd_nxt    = is_rd_p0;
    wait_cnt_nxt = wait_cnt_p0;
    timeout_nxt  = timeout_p0;
    accept       = 1'b0;

    case (state_p0)
      S_IDLE: begin
        if (req) begin
          state_nxt = S_T1;
          accept    = 1'b1;
        end
      end
      S_T1: begin
        state_nxt = S_T2;
      end
      S_T2: begin
        state_nxt = bus.nwait ? S_T3 : S_TW;
      end
      S_TW: begin
        if (WAIT_TIMEOUT > 0) begin
          wait_cnt_nxt = wait_cnt_p0 + CNT_W'(1);
        end
        if (timeout_hit) begin
          state_nxt   = S_T3;
          timeout_nxt = 1'b1;
        end else if (bus.nwait) begin
          state_nxt = S_T3;
        end
      end
      S_T3: begin
        // A request landing in T3 chains straight into the next T1.
        if (req) begin
          state_nxt = S_T1;
          accept    = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Read wins a simultaneous request; the write byte is then discarded.
    if (accept) begin
      is_rd_nxt    = bus.rd_req;
      wait_cnt_nxt = '0;
      timeout_nxt  = 1'b0;
    end

    wr_cap = accept & ~bus.rd_req;

    // Capture and completion pulses belong to the cycle that is finishing,
    // so they use the current flags, not the ones latched for a chained cycle.
    rd_cap   = finish & is_rd_p0 & ~timeout_p0;
    done_nxt = finish;
    err_nxt  = finish & timeout_p0;
    lwe_nxt  = rd_cap;

    busy_nxt  = (state_nxt != S_IDLE);
    nmreq_nxt = ~busy_nxt;
    nrd_nxt   = ~(busy_nxt & is_rd_nxt);
    // nwr leaves T1 and T3 inactive for address/data setup and hold.
    nwr_nxt   = ~(((state_nxt == S_T2) || (state_nxt == S_TW)) & ~is_rd_nxt);
    oe_nxt    = busy_nxt & ~is_rd_nxt;
  end

  // Stage p0: FSM state and per-cycle flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0    <= S_IDLE;
      is_rd_p0    <= 1'b0;
      wait_cnt_p0 <= '0;
      timeout_p0  <= 1'b0;
    end else begin
      state_p0    <= state_nxt;
      is_rd_p0    <= is_rd_nxt;
      wait_cnt_p0 <= wait_cnt_nxt;
      timeout_p0  <= timeout_nxt;
    end
  end

  // Stage p0: registered bus strobes, pin data and read capture
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.nmreq     <= 1'b1;
      bus.nrd       <= 1'b1;
      bus.nwr       <= 1'b1;
      bus.pin_d_oe  <= 1'b0;
      bus.pin_d_out <= '0;
      bus.rd_data   <= '0;
      bus.latch_we  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.nmreq    <= nmreq_nxt;
      bus.nrd      <= nrd_nxt;
      bus.nwr      <= nwr_nxt;
      bus.pin_d_oe <= oe_nxt;
      bus.latch_we <= lwe_nxt;
      bus.busy     <= busy_nxt;
      bus.done     <= done_nxt;
      bus.err      <= err_nxt;
      if (wr_cap) begin
        bus.pin_d_out <= bus.wr_data;
      end
      if (rd_cap) begin
        bus.rd_data <= bus.pin_d_in;
      end
    end
  end

endmodule

// File: tb/tb_data_bus_seq.sv
// tb_data_bus_seq
//   Directed bench for data_bus_seq. The stimulus is a per-cycle table; a
//   transaction-level model turns the table into per-cycle expected outputs,
//   and one loop drives the table and compares every output every cycle,
//   plus literal expectations at hand-picked cycles.
module tb_data_bus_seq;
  localparam int DW = 8;
  localparam int TO = 4;
  localparam int N  = 72;
  localparam int M  = N + 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_bus_seq_if #(.DW(DW)) bus ();

  data_bus_seq #(.DW(DW), .WAIT_TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // stimulus table
  logic       s_rst [N];
  logic       s_rd  [N];
  logic       s_wr  [N];
  logic       s_nw  [N];
  logic [7:0] s_wd  [N];
  logic [7:0] s_pin [N];

  // expected outputs per cycle
  logic       e_nmreq [M];
  logic       e_nrd   [M];
  logic       e_nwr   [M];
  logic       e_oe    [M];
  logic       e_busy  [M];
  logic       e_done  [M];
  logic       e_err   [M];
  logic       e_lwe   [M];
  logic       rcv     [M];
  logic [7:0] rval    [M];
  logic       wcv     [M];
  logic [7:0] wval    [M];
  logic [7:0] e_rdd   [M];
  logic [7:0] e_pdo   [M];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int cyc, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  task automatic set_pin(input int a, input int b, input logic [7:0] v);
    for (int i = a; i <= b; i++) s_pin[i] = v;
  endtask

  task automatic nw_low(input int a, input int b);
    for (int i = a; i <= b; i++) s_nw[i] = 1'b0;
  endtask

  task automatic build_stim();
    for (int i = 0; i < N; i++) begin
      s_rst[i] = 1'b0; s_rd[i] = 1'b0; s_wr[i] = 1'b0;
      s_nw[i] = 1'b1; s_wd[i] = 8'h00; s_pin[i] = 8'h00;
    end
    s_rst[0] = 1'b1; s_rst[1] = 1'b1;
    // plain read
    s_rd[4] = 1'b1; set_pin(4, 9, 8'hAA);
    // write
    s_wr[10] = 1'b1; s_wd[10] = 8'h55;
    // read with two waits, chained read requested in its T3
    s_rd[16] = 1'b1; set_pin(16, 21, 8'h99); nw_low(18, 19);
    s_rd[21] = 1'b1; set_pin(22, 24, 8'h3C);
    // simultaneous rd+wr, then a write pulse during T2
    s_rd[28] = 1'b1; s_wr[28] = 1'b1; s_wd[28] = 8'hA5; set_pin(28, 32, 8'h5A);
    s_wr[30] = 1'b1; s_wd[30] = 8'h77;
    // timeout read
    s_rd[36] = 1'b1; set_pin(36, 46, 8'hE1); nw_low(38, 46);
    // write aborted by reset in TW
    s_wr[50] = 1'b1; s_wd[50] = 8'hC3; nw_low(52, 56); s_rst[54] = 1'b1;
    // write then chained read
    s_wr[60] = 1'b1; s_wd[60] = 8'h0F; s_rd[63] = 1'b1; set_pin(64, 66, 8'h81);
  endtask

  task automatic run_model();
    int free_from;
    int c, w, d;
    logic rd, to;
    logic [7:0] cur_rd, cur_pdo;
    for (int j = 0; j < M; j++) begin
      e_nmreq[j] = 1'b1; e_nrd[j] = 1'b1; e_nwr[j] = 1'b1; e_oe[j] = 1'b0;
      e_busy[j] = 1'b0; e_done[j] = 1'b0; e_err[j] = 1'b0; e_lwe[j] = 1'b0;
      rcv[j] = 1'b0; rval[j] = 8'h00; wcv[j] = 1'b0; wval[j] = 8'h00;
      e_rdd[j] = 8'h00; e_pdo[j] = 8'h00;
    end
    free_from = 0;
    for (int k = 0; k < N; k++) begin
      if (s_rst[k]) begin
        // everything after a reset cycle starts from idle again
        for (int j = k + 1; j < M; j++) begin
          e_nmreq[j] = 1'b1; e_nrd[j] = 1'b1; e_nwr[j] = 1'b1; e_oe[j] = 1'b0;
          e_busy[j] = 1'b0; e_done[j] = 1'b0; e_err[j] = 1'b0; e_lwe[j] = 1'b0;
          rcv[j] = 1'b0; wcv[j] = 1'b0;
        end
        free_from = k + 1;
      end else if (k >= free_from && (s_rd[k] || s_wr[k])) begin
        c  = k + 1;
        rd = s_rd[k];
        w  = 0;
        while ((c + 1 + w) < N && s_nw[c + 1 + w] == 1'b0 && w < TO) w++;
        to = (w == TO);
        for (int j = c; j <= c + 2 + w; j++) begin
          e_nmreq[j] = 1'b0; e_busy[j] = 1'b1;
          if (rd) e_nrd[j] = 1'b0; else e_oe[j] = 1'b1;
        end
        if (!rd) for (int j = c + 1; j <= c + 1 + w; j++) e_nwr[j] = 1'b0;
        d = c + 3 + w;
        e_done[d] = 1'b1;
        e_err[d]  = to;
        e_lwe[d]  = rd && !to;
        if (rd && !to) begin rcv[d] = 1'b1; rval[d] = s_pin[c + 2 + w]; end
        if (!rd) begin wcv[c] = 1'b1; wval[c] = s_wd[k]; end
        free_from = c + 2 + w;
      end
    end
    cur_rd = 8'h00; cur_pdo = 8'h00;
    for (int j = 1; j < N; j++) begin
      if (s_rst[j - 1]) begin
        cur_rd = 8'h00; cur_pdo = 8'h00;
      end else begin
        if (rcv[j]) cur_rd = rval[j];
        if (wcv[j]) cur_pdo = wval[j];
      end
      e_rdd[j] = cur_rd;
      e_pdo[j] = cur_pdo;
    end
  endtask

  task automatic drive(input int n);
    reset        = s_rst[n];
    bus.rd_req   = s_rd[n];
    bus.wr_req   = s_wr[n];
    bus.wr_data  = s_wd[n];
    bus.nwait    = s_nw[n];
    bus.pin_d_in = s_pin[n];
  endtask

  task automatic compare(input int n);
    chk("nmreq",     n, {7'd0, bus.nmreq},    {7'd0, e_nmreq[n]});
    chk("nrd",       n, {7'd0, bus.nrd},      {7'd0, e_nrd[n]});
    chk("nwr",       n, {7'd0, bus.nwr},      {7'd0, e_nwr[n]});
    chk("pin_d_oe",  n, {7'd0, bus.pin_d_oe}, {7'd0, e_oe[n]});
    chk("busy",      n, {7'd0, bus.busy},     {7'd0, e_busy[n]});
    chk("done",      n, {7'd0, bus.done},     {7'd0, e_done[n]});
    chk("err",       n, {7'd0, bus.err},      {7'd0, e_err[n]});
    chk("latch_we",  n, {7'd0, bus.latch_we}, {7'd0, e_lwe[n]});
    chk("rd_data",   n, bus.rd_data,          e_rdd[n]);
    chk("pin_d_out", n, bus.pin_d_out,        e_pdo[n]);
  endtask

  task automatic literal_checks(input int n);
    case (n)
      2: begin
        chk("lit_reset_nmreq", n, {7'd0, bus.nmreq}, 8'h01);
        chk("lit_reset_busy",  n, {7'd0, bus.busy},  8'h00);
        chk("lit_reset_rd",    n, bus.rd_data,       8'h00);
      end
      5, 6, 7: chk("lit_read_nrd", n, {7'd0, bus.nrd}, 8'h00);
      8: begin
        chk("lit_read_lwe",   n, {7'd0, bus.latch_we}, 8'h01);
        chk("lit_read_done",  n, {7'd0, bus.done},     8'h01);
        chk("lit_read_data",  n, bus.rd_data,          8'hAA);
        chk("model_lwe_c8",   n, {7'd0, e_lwe[8]},     8'h01);
      end
      11: chk("lit_wr_pdo", n, bus.pin_d_out, 8'h55);
      12: chk("lit_wr_nwr_t2", n, {7'd0, bus.nwr}, 8'h00);
      13: chk("lit_wr_nwr_t3", n, {7'd0, bus.nwr}, 8'h01);
      14: begin
        chk("lit_wr_done", n, {7'd0, bus.done},     8'h01);
        chk("lit_wr_lwe",  n, {7'd0, bus.latch_we}, 8'h00);
      end
      22: begin
        chk("lit_b2b_lwe",   n, {7'd0, bus.latch_we}, 8'h01);
        chk("lit_b2b_nmreq", n, {7'd0, bus.nmreq},    8'h00);
        chk("lit_b2b_rd1",   n, bus.rd_data,          8'h99);
      end
      25: chk("lit_b2b_rd2", n, bus.rd_data, 8'h3C);
      30: chk("lit_coll_nwr", n, {7'd0, bus.nwr}, 8'h01);
      32: begin
        chk("lit_coll_pdo", n, bus.pin_d_out, 8'h55);
        chk("lit_coll_rd",  n, bus.rd_data,   8'h5A);
      end
      33: chk("lit_coll_busy", n, {7'd0, bus.busy}, 8'h00);
      42: chk("lit_to_tw4", n, {7'd0, bus.nrd}, 8'h00);
      44: begin
        chk("lit_to_err",  n, {7'd0, bus.err},      8'h01);
        chk("lit_to_done", n, {7'd0, bus.done},     8'h01);
        chk("lit_to_lwe",  n, {7'd0, bus.latch_we}, 8'h00);
        chk("lit_to_rd",   n, bus.rd_data,          8'h5A);
        chk("model_err_c44", n, {7'd0, e_err[44]},  8'h01);
      end
      55: begin
        chk("lit_rst_nmreq", n, {7'd0, bus.nmreq},    8'h01);
        chk("lit_rst_nwr",   n, {7'd0, bus.nwr},      8'h01);
        chk("lit_rst_oe",    n, {7'd0, bus.pin_d_oe}, 8'h00);
        chk("lit_rst_pdo",   n, bus.pin_d_out,        8'h00);
      end
      56: chk("lit_rst_nodone", n, {7'd0, bus.done}, 8'h00);
      67: chk("lit_wr_rd_b2b", n, bus.rd_data, 8'h81);
      default: ;
    endcase
  endtask

  initial begin
    build_stim();
    run_model();
    drive(0);
    for (int n = 1; n < N; n++) begin
      @(posedge clk);
      #1;
      drive(n);
      @(negedge clk);
      compare(n);
      literal_checks(n);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
